// File: rtl/gold_router_vc_if.sv
// Handshake and flit bundle for the five-port VC mesh router.
// master drives inputs/downstream-ready, slave is the router.
interface gold_router_vc_if #(
   parameter int unsigned PACKET_SIZE = 64
);
   logic                   cwsi, ccwsi, nssi, snsi, pesi;
   logic                   cwri, ccwri, nsri, snri, peri;
   logic [PACKET_SIZE-1:0] cwdi, ccwdi, nsdi, sndi, pedi;
   logic                   cwso, ccwso, nsso, snso, peso;
   logic                   cwro, ccwro, nsro, snro, pero;
   logic [PACKET_SIZE-1:0] cwdo, ccwdo, nsdo, sndo, pedo;

   modport master (
      output cwsi, ccwsi, nssi, snsi, pesi,
      output cwdi, ccwdi, nsdi, sndi, pedi,
      output cwro, ccwro, nsro, snro, pero,
      input  cwri, ccwri, nsri, snri, peri,
      input  cwso, ccwso, nsso, snso, peso,
      input  cwdo, ccwdo, nsdo, sndo, pedo
   );

   modport slave (
      input  cwsi, ccwsi, nssi, snsi, pesi,
      input  cwdi, ccwdi, nsdi, sndi, pedi,
      input  cwro, ccwro, nsro, snro, pero,
      output cwri, ccwri, nsri, snri, peri,
      output cwso, ccwso, nsso, snso, peso,
      output cwdo, ccwdo, nsdo, sndo, pedo
   );
endinterface

// File: rtl/gold_router_vc.sv
// Five-port mesh router with two polarity VCs: per-input/per-VC FIFOs, one output
// register per port per VC and round-robin arbitration per output per VC.
module gold_router_vc #(
   parameter int unsigned PACKET_SIZE = 64,
   parameter int unsigned DEPTH       = 2
) (
   input logic           clk,
   input logic           reset,
   input logic           polarity,
   gold_router_vc_if.slave bus
);
   localparam int          NP = 5;
   localparam int unsigned PS = PACKET_SIZE;
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   localparam logic [2:0] PortCw  = 3'd0;
   localparam logic [2:0] PortCcw = 3'd1;
   localparam logic [2:0] PortNs  = 3'd2;
   localparam logic [2:0] PortSn  = 3'd3;
   localparam logic [2:0] PortPe  = 3'd4;

   logic [NP-1:0] si, ri, so, ro;
   logic [PS-1:0] di   [NP];
   logic [PS-1:0] dout [NP];

   assign si = {bus.pesi, bus.snsi, bus.nssi, bus.ccwsi, bus.cwsi};
   assign ro = {bus.pero, bus.snro, bus.nsro, bus.ccwro, bus.cwro};
   assign di[0] = bus.cwdi;
   assign di[1] = bus.ccwdi;
   assign di[2] = bus.nsdi;
   assign di[3] = bus.sndi;
   assign di[4] = bus.pedi;

   assign bus.cwri  = ri[0];
   assign bus.ccwri = ri[1];
   assign bus.nsri  = ri[2];
   assign bus.snri  = ri[3];
   assign bus.peri  = ri[4];
   assign bus.cwso  = so[0];
   assign bus.ccwso = so[1];
   assign bus.nsso  = so[2];
   assign bus.snso  = so[3];
   assign bus.peso  = so[4];
   assign bus.cwdo  = dout[0];
   assign bus.ccwdo = dout[1];
   assign bus.nsdo  = dout[2];
   assign bus.sndo  = dout[3];
   assign bus.pedo  = dout[4];

   // Link side uses VC ~polarity, switch side uses VC polarity.
   logic vi, vs;
   assign vi = ~polarity;
   assign vs = polarity;

   logic [PS-1:0] mem_q    [NP][2][DEPTH];
   logic [PW-1:0] rd_q     [NP][2];
   logic [PW-1:0] wr_q     [NP][2];
   logic [CW-1:0] cnt_q    [NP][2];
   logic [PS-1:0] odata_q  [NP][2];
   logic [1:0]    ovalid_q [NP];
   logic [2:0]    rr_q     [NP][2];

   logic [NP-1:0] push, req, pop, gnt;
   logic [2:0]    dst  [NP];
   logic [2:0]    win  [NP];
   logic [PS-1:0] head [NP];
   logic [PS-1:0] fwd  [NP];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      for (int x = 0; x < NP; x++) begin
         ri[x]   = !reset && (cnt_q[x][vi] != CW'(DEPTH));
         push[x] = si[x] && ri[x];
         so[x]   = !reset && ovalid_q[x][vi];
         dout[x] = so[x] ? odata_q[x][vi] : '0;
      end
   end

   // Route each head: horizontal hops first, then vertical, then local delivery.
   always_comb begin
      for (int x = 0; x < NP; x++) begin
         head[x] = mem_q[x][vs][rd_q[x][vs]];
         req[x]  = (cnt_q[x][vs] != '0);
         fwd[x]  = head[x];
         if (head[x][PS-9 -: 4] != 4'd0) begin
            dst[x] = head[x][PS-2] ? PortCcw : PortCw;
            fwd[x][PS-9 -: 4] = head[x][PS-9 -: 4] - 4'd1;
         end else if (head[x][PS-13 -: 4] != 4'd0) begin
            dst[x] = head[x][PS-3] ? PortSn : PortNs;
            fwd[x][PS-13 -: 4] = head[x][PS-13 -: 4] - 4'd1;
         end else begin
            dst[x] = PortPe;
         end
      end
   end

   always_comb begin
      logic [3:0] sum;
      logic [2:0] pi;
      gnt = '0;
      pop = '0;
      sum = '0;
      pi  = '0;
      for (int o = 0; o < NP; o++) begin
         win[o] = '0;
         if (!ovalid_q[o][vs]) begin
            for (int k = 0; k < NP; k++) begin
               sum = {1'b0, rr_q[o][vs]} + 4'(k);
               pi  = (sum >= 4'(NP)) ? 3'(sum - 4'(NP)) : sum[2:0];
               if (!gnt[o] && req[pi] && (dst[pi] == 3'(o))) begin
                  gnt[o] = 1'b1;
                  win[o] = pi;
               end
            end
         end
         if (gnt[o]) pop[win[o]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int x = 0; x < NP; x++) begin
            ovalid_q[x] <= '0;
            for (int v = 0; v < 2; v++) begin
               cnt_q[x][v] <= '0;
               rd_q[x][v]  <= '0;
               wr_q[x][v]  <= '0;
               rr_q[x][v]  <= PortCw;
            end
         end
      end else begin
         for (int x = 0; x < NP; x++) begin
            if (push[x]) begin
               wr_q[x][vi]  <= ptr_inc(wr_q[x][vi]);
               cnt_q[x][vi] <= cnt_q[x][vi] + 1'b1;
            end
            if (pop[x]) begin
               rd_q[x][vs]  <= ptr_inc(rd_q[x][vs]);
               cnt_q[x][vs] <= cnt_q[x][vs] - 1'b1;
            end
            if (so[x] && ro[x]) ovalid_q[x][vi] <= 1'b0;
            if (gnt[x]) begin
               ovalid_q[x][vs] <= 1'b1;
               rr_q[x][vs]     <= (win[x] == PortPe) ? PortCw : win[x] + 3'd1;
            end
         end
      end
   end

   // Payload storage needs no reset; occupancy is tracked by counts and valids.
   always_ff @(posedge clk) begin
      for (int x = 0; x < NP; x++) begin
         if (push[x]) mem_q[x][vi][wr_q[x][vi]] <= di[x];
         if (gnt[x])  odata_q[x][vs] <= fwd[win[x]];
      end
   end
endmodule
